// File: rtl/pc_unit.sv
// Program-counter unit: sequential/branch/jump/call/return with a circular
// return-address stack.
module pc_unit #(
  parameter int unsigned       WIDTH     = 16,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  parameter int unsigned       INC       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           offset,
  input  logic [WIDTH-1:0]           target,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH):0]     ras_count,
  output logic                       ras_full,
  output logic                       ras_empty,
  output logic                       ras_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] ras_q [DEPTH];
  logic             push_en;
  logic [WIDTH-1:0] pc_inc;
  logic             full_c, empty_c;

  assign pc_inc  = pc_q + WIDTH'(INC);
  assign full_c  = (cnt_q == CW'(DEPTH));
  assign empty_c = (cnt_q == '0);

  // Next-PC and RAS pointer/count/error selection.
  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (!stall) begin
      case (op)
        OP_BR:   pc_d = pc_q + offset;
        OP_JMP:  pc_d = target;
        OP_CALL: begin
          push_en = 1'b1;
          pc_d    = target;
          sp_d    = sp_q + PW'(1);
          if (full_c) err_d = 1'b1;
          else        cnt_d = cnt_q + CW'(1);
        end
        OP_RET: begin
          if (empty_c) begin
            pc_d  = pc_inc;
            err_d = 1'b1;
          end else begin
            pc_d  = ras_q[sp_q - PW'(1)];
            sp_d  = sp_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  // PC and RAS control state; reset clears everything except entry contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // RAS entry storage; a full-stack push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (push_en) ras_q[sp_q] <= pc_inc;
  end

  assign pc        = pc_q;
  assign ras_count = cnt_q;
  assign ras_full  = full_c;
  assign ras_empty = empty_c;
  assign ras_err   = err_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle CPU, replacing the fixed 16-bit PC register. It holds the fetch address and updates it once per clock by sequential increment, relative branch, absolute jump, call or return. Calls and returns go through an internal circular return-address stack (RAS). Its output drives the instruction memory address. The control unit supplies the op, and the datapath supplies the branch offset and jump target.

## Interface
- WIDTH, 16, address width in bits (≥ 4)
- DEPTH, 4, RAS entries; power of two, ≥ 2
- RESET_VEC, 0, PC value on reset (WIDTH bits)
- INC, 1, sequential increment (instruction size in address units)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all state this cycle; op ignored
- op  in  3  0 SEQ, 1 BR, 2 JMP, 3 CALL, 4 RET; 5–7 behave as SEQ
- offset  in  WIDTH  two's-complement branch offset (BR)
- target  in  WIDTH  absolute destination (JMP, CALL)
- pc  out  WIDTH  current fetch address (registered)
- ras_count  out  $clog2(DEPTH)+1  valid RAS entries, 0..DEPTH
- ras_full  out  1  ras_count == DEPTH
- ras_empty  out  1  ras_count == 0
- ras_err  out  1  sticky: overflow or underflow has occurred

## Operation
- Next-PC selection, evaluated when stall=0:
  - SEQ: pc + INC
  - BR: pc + offset
  - JMP: target
  - CALL: push pc + INC, then pc = target
  - RET: pc = top entry, then pop
- All address arithmetic is modulo 2^WIDTH; carries are discarded, so 0xFFFF + 1 wraps to 0x0000 at WIDTH=16.
- RAS storage:
  - DEPTH registers addressed by a WIDTH-independent top pointer `sp`.
  - A push writes entry[sp] and then increments sp modulo DEPTH.
  - A pop reads entry[sp-1] and then decrements sp modulo DEPTH.
- CALL when full: the push still happens, overwriting the oldest entry (circular). ras_count stays at DEPTH and ras_err is set.
- RET when empty: pc = pc + INC, with no pop. sp and count are unchanged and ras_err is set.
- ras_err is cleared only by reset.
- stall=1: pc, sp, count, entries and ras_err all hold; op, offset and target are don't-care.
- ras_full and ras_empty are combinational decodes of ras_count.
- Reset (async assert, any time including mid-operation):
  - pc = RESET_VEC, sp = 0, ras_count = 0, ras_err = 0, so ras_empty = 1 and ras_full = 0.
  - RAS entry contents need not be cleared.

## Timing
- Inputs op, offset, target and stall are sampled at the rising clk edge. pc takes the new value on that same edge, so there is one cycle of latency from op to the visible pc.
- pc is valid throughout the cycle that follows an edge, and is purely registered: there is no combinational path from inputs to pc.
- ras_count, ras_full, ras_empty and ras_err update on the same edge as pc.
- Reset assertion takes effect immediately, without waiting for clk.
- Reset deassertion is synchronised externally. The first rising edge with rst_n=1 executes the op presented at that edge.
- CALL followed immediately by RET on the next cycle returns to the CALL's pc + INC. No bypass hazard exists because the push is committed at the CALL edge.

## Test plan
- Reset/sequential (WIDTH=16, RESET_VEC=0x0100, INC=1):
  - Drive rst_n low, then release and apply SEQ for 3 edges.
  - Required: pc = 0x0100 while in reset, then 0x0101, 0x0102, 0x0103; ras_empty = 1; ras_err = 0.
- Branch/jump/wrap:
  - From pc=0x0010, BR offset=0xFFF0 → pc = 0x0000.
  - JMP target=0xFFFF → 0xFFFF. SEQ → 0x0000.
- Nested call/return (DEPTH=4):
  - From pc=0x0020: CALL 0x0100, then CALL 0x0200.
  - Required after the two CALLs: ras_count = 2.
  - RET → 0x0101, then RET → 0x0021, then ras_empty = 1.
- Overflow:
  - 5 CALLs from pcs 0x00, 0x10, 0x20, 0x30, 0x40, each with target = pc + 0x10.
  - Required after the CALLs: ras_full = 1, ras_err = 1.
  - 4 RETs → 0x41, 0x31, 0x21, 0x11; ras_empty = 1.
- Underflow/stall:
  - RET when empty at pc=0x0050 → pc = 0x0051, ras_err = 1.
  - Then stall=1 for 3 edges with op=JMP target=0x0AAA → pc stays at 0x0051.
- Async reset mid-operation:
  - With ras_count=3 and ras_err=1, pulse rst_n low between edges.
  - Required: pc = RESET_VEC, ras_count = 0, ras_err = 0 before the next edge.
